// File: rtl/clb_array_cfg.sv
// Configurable logic block tile: W independent slices (4-input LUT, enable-gated
// flip-flop, per-side output routing) configured via a serial shadow chain that
// commits atomically into the active configuration.
module clb_array_cfg #(
  parameter int W        = 1,
  parameter int SLICE_CB = 24,
  parameter int CFG_BITS = SLICE_CB * W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] up_i,
  input  logic [W-1:0] down_i,
  input  logic [W-1:0] right_i,
  input  logic [W-1:0] left_i,
  output logic [W-1:0] up_o,
  output logic [W-1:0] down_o,
  output logic [W-1:0] right_o,
  output logic [W-1:0] left_o,
  input  logic         cfg_shift,
  input  logic         cfg_din,
  output logic         cfg_dout,
  input  logic         cfg_commit,
  output logic         cfg_full,
  output logic         cfg_done
);

  localparam int CW = $clog2(CFG_BITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(CFG_BITS);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CFG_BITS-1:0] shadow_q;
  logic [CFG_BITS-1:0] active_q;
  logic [CW-1:0]       cfg_cnt_q;
  logic                done_q;
  logic                commit_ok;
  logic [W-1:0]        ff_q;
  logic [W-1:0]        lut_out;
  logic [W-1:0]        ff_en;
  logic [W-1:0]        init_new;

  assign cfg_full  = (cfg_cnt_q == CNT_FULL);
  assign commit_ok = cfg_commit & cfg_full;
  assign cfg_dout  = shadow_q[0];
  assign cfg_done  = done_q;

  for (genvar g = 0; g < W; g++) begin : g_slice
    logic [SLICE_CB-1:0] cfg;
    logic [3:0]          addr;
    logic                lut_bit;
    logic                en_bit;
    logic                sig;
    logic                uo, dn, ro, lo;

    assign cfg         = active_q[SLICE_CB*g +: SLICE_CB];
    // ff_init is taken from the shadow so a commit loads the incoming config's value
    assign init_new[g] = shadow_q[SLICE_CB*g + 16];
    assign lut_out[g]  = lut_bit;
    assign ff_en[g]    = en_bit;
    assign up_o[g]     = uo;
    assign down_o[g]   = dn;
    assign right_o[g]  = ro;
    assign left_o[g]   = lo;

    // LUT lookup, enable select and per-side routing for this slice
    always_comb begin
      addr    = {up_i[g], down_i[g], right_i[g], left_i[g]};
      lut_bit = cfg[addr];
      unique case (cfg[18:17])
        2'b00:   en_bit = left_i[g];
        2'b01:   en_bit = right_i[g];
        2'b10:   en_bit = 1'b1;
        default: en_bit = up_i[g];
      endcase
      sig = cfg[19] ? lut_bit : ff_q[g];
      uo  = cfg[23] ? sig : down_i[g];
      dn  = cfg[22] ? sig : up_i[g];
      ro  = cfg[21] ? sig : left_i[g];
      lo  = cfg[20] ? sig : right_i[g];
    end
  end

  // Shift chain, saturating fill counter, atomic commit and done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_q  <= '0;
      active_q  <= '0;
      cfg_cnt_q <= '0;
      done_q    <= 1'b0;
    end else begin
      if (cfg_shift) shadow_q <= {cfg_din, shadow_q[CFG_BITS-1:1]};
      if (commit_ok) begin
        active_q  <= shadow_q;
        cfg_cnt_q <= cfg_shift ? CNT_ONE : '0;
      end else if (cfg_shift && !cfg_full) begin
        cfg_cnt_q <= cfg_cnt_q + CNT_ONE;
      end
      done_q <= commit_ok;
    end
  end

  // Slice flip-flops: commit forces ff_init, otherwise enabled load of the LUT output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff_q <= '0;
    else if (commit_ok) ff_q <= init_new;
    else ff_q <= (ff_en & lut_out) | (~ff_en & ff_q);
  end

endmodule
